// File: rtl/aging_alarm_gen.sv
// Windowed timing-error rate monitor: counts synchronized rising edges from the
// shadow-register comparators per window and drives a hysteretic aging alarm.
module aging_alarm_gen #(
    parameter int CLK_FREQ      = 20000000,
    parameter int WINDOW_CYCLES = CLK_FREQ / 10,
    parameter int NUM_SENSORS   = 4,
    parameter int SET_THRESH    = 16,
    parameter int CLR_THRESH    = 4,
    parameter int SET_WINDOWS   = 2,
    parameter int CLR_WINDOWS   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] err_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    output logic                   aging_alarm,
    output logic [15:0]            err_count_o,
    output logic                   count_valid_o,
    output logic                   sticky_o
);

    localparam int WIN_W    = $clog2(WINDOW_CYCLES);
    localparam int INC_W    = $clog2(NUM_SENSORS + 1);
    localparam int MAX_WIN  = (SET_WINDOWS > CLR_WINDOWS) ? SET_WINDOWS : CLR_WINDOWS;
    localparam int STREAK_W = $clog2(MAX_WIN + 1);

    localparam logic [WIN_W-1:0]    WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [STREAK_W-1:0] SET_STREAK = STREAK_W'(SET_WINDOWS);
    localparam logic [STREAK_W-1:0] CLR_STREAK = STREAK_W'(CLR_WINDOWS);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [15:0]         SET_T      = 16'(SET_THRESH);
    localparam logic [15:0]         CLR_T      = 16'(CLR_THRESH);

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_PEND_SET = 2'd1,
        ST_ALARM    = 2'd2,
        ST_PEND_CLR = 2'd3
    } state_t;

    logic [NUM_SENSORS-1:0] edge_w;

    // prev starts at 0, so a level already high at reset release counts once
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                end else begin
                    sync1_reg <= err_i[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                end
            end

            assign edge_w[gi] = sync2_reg & ~prev_reg;
        end
    endgenerate

    logic [INC_W-1:0] inc_w;
    always_comb begin
        inc_w = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            inc_w = inc_w + INC_W'(edge_w[i]);
        end
    end

    logic [WIN_W-1:0]    win_cnt_reg;
    logic [15:0]         acc_reg;
    logic [16:0]         sum_w;
    logic [15:0]         total_w;
    logic                win_close_w;
    state_t              state_reg, state_next;
    logic [STREAK_W-1:0] streak_reg, streak_next, streak_inc_w;
    logic                enter_alarm_w;

    assign sum_w         = {1'b0, acc_reg} + 17'(inc_w);
    assign total_w       = sum_w[16] ? 16'hFFFF : sum_w[15:0];
    assign win_close_w   = enable_i && (win_cnt_reg == WIN_LAST);
    assign streak_inc_w  = streak_reg + STREAK_ONE;
    assign enter_alarm_w = (state_next == ST_ALARM) && (state_reg != ST_ALARM);

    always_comb begin
        state_next  = state_reg;
        streak_next = streak_reg;
        if (win_close_w) begin
            case (state_reg)
                ST_OK: begin
                    if (total_w >= SET_T) begin
                        if (SET_WINDOWS == 1) begin
                            state_next = ST_ALARM;
                        end else begin
                            state_next  = ST_PEND_SET;
                            streak_next = STREAK_ONE;
                        end
                    end
                end
                ST_PEND_SET: begin
                    if (total_w >= SET_T) begin
                        if (streak_inc_w == SET_STREAK) begin
                            state_next  = ST_ALARM;
                            streak_next = '0;
                        end else begin
                            streak_next = streak_inc_w;
                        end
                    end else begin
                        state_next  = ST_OK;
                        streak_next = '0;
                    end
                end
                ST_ALARM: begin
                    if (total_w <= CLR_T) begin
                        if (CLR_WINDOWS == 1) begin
                            state_next = ST_OK;
                        end else begin
                            state_next  = ST_PEND_CLR;
                            streak_next = STREAK_ONE;
                        end
                    end
                end
                ST_PEND_CLR: begin
                    if (total_w <= CLR_T) begin
                        if (streak_inc_w == CLR_STREAK) begin
                            state_next  = ST_OK;
                            streak_next = '0;
                        end else begin
                            streak_next = streak_inc_w;
                        end
                    end else begin
                        state_next  = ST_ALARM;
                        streak_next = '0;
                    end
                end
                default: begin
                    state_next  = ST_OK;
                    streak_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_reg   <= '0;
            acc_reg       <= '0;
            err_count_o   <= '0;
            count_valid_o <= 1'b0;
            state_reg     <= ST_OK;
            streak_reg    <= '0;
            aging_alarm   <= 1'b0;
            sticky_o      <= 1'b0;
        end else begin
            count_valid_o <= 1'b0;
            if (!enable_i) begin
                win_cnt_reg <= '0;
                acc_reg     <= '0;
            end else if (win_close_w) begin
                win_cnt_reg   <= '0;
                acc_reg       <= '0;
                err_count_o   <= total_w;
                count_valid_o <= 1'b1;
            end else begin
                win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                acc_reg     <= total_w;
            end
            state_reg   <= state_next;
            streak_reg  <= streak_next;
            aging_alarm <= (state_next == ST_ALARM) || (state_next == ST_PEND_CLR);
            // a new alarm entry beats a simultaneous software clear
            if (enter_alarm_w) begin
                sticky_o <= 1'b1;
            end else if (clear_i) begin
                sticky_o <= 1'b0;
            end
        end
    end

endmodule
